// File: rtl/seg_pkg.sv
// Shared segment constants and page encoding for the seven-segment scanner.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    typedef enum logic {
        PageMmSs = 1'b0,
        PageSsCc = 1'b1
    } page_e;

    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegBlank = 7'b1111111;

    localparam logic [3:0] AnOff    = 4'b1111;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD-to-seven-segment decoder, active-low outputs.
// Non-BCD nibbles (10..15) show a dash.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SegDash;
        case (bcd)
            4'd0: seg = Seg0;
            4'd1: seg = Seg1;
            4'd2: seg = Seg2;
            4'd3: seg = Seg3;
            4'd4: seg = Seg4;
            4'd5: seg = Seg5;
            4'd6: seg = Seg6;
            4'd7: seg = Seg7;
            4'd8: seg = Seg8;
            4'd9: seg = Seg9;
            default: seg = SegDash;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with per-frame input snapshot.
// Optional blink feature enabled by defining SEG_BLINK_EN.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bcd_in,
    input  logic        page_sel,
    input  logic        blank_en,
`ifdef SEG_BLINK_EN
    input  logic        blink,
`endif
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned PW = $clog2(SCAN_DIV);

    if (SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
        $error("seven_seg_scan: SCAN_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic [23:0]   snap_bcd_q;
    page_e         snap_page_q;
    logic          tick_q;
    logic          blank_q;

    logic          tick;
    logic          wrap;
    logic [2:0]    sel;
    logic [3:0]    digit;
    logic [6:0]    dec_seg;
    logic          blank_slot;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;
    logic          dp_d;

    assign tick = (presc_q == PW'(SCAN_DIV - 1));
    assign wrap = tick && (idx_q == 2'd3);

`ifdef SEG_BLINK_EN
    localparam int unsigned FW = $clog2(2 * BLINK_FRAMES);

    logic [FW-1:0] frame_q;
    logic          started_q;

    // The idx=3 slot right after reset is not a real frame, so the first wrap
    // does not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q   <= '0;
            started_q <= 1'b0;
        end else begin
            if (wrap) begin
                started_q <= 1'b1;
            end
            if (!blink) begin
                frame_q <= '0;
            end else if (wrap && started_q) begin
                frame_q <= (frame_q == FW'(2 * BLINK_FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end
        end
    end
`endif

    // Page 0 shifts the window up two nibbles to drop the centiseconds.
    always_comb begin
        sel   = {1'b0, idx_q} + ((snap_page_q == PageSsCc) ? 3'd0 : 3'd2);
        digit = 4'(snap_bcd_q >> {sel, 2'b00});
    end

    seg_decoder u_seg_decoder (
        .bcd (digit),
        .seg (dec_seg)
    );

    always_comb begin
        blank_slot = blank_q && (idx_q == 2'd3) && (digit == 4'd0);
        seg_d      = blank_slot ? SegBlank : dec_seg;
        an_d       = blank_slot ? AnOff : ~(4'b0001 << idx_q);
        dp_d       = (idx_q != 2'd2);
`ifdef SEG_BLINK_EN
        if (blink && (frame_q >= FW'(BLINK_FRAMES))) begin
            an_d = AnOff;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= 2'd3;
            snap_bcd_q  <= '0;
            snap_page_q <= PageMmSs;
            tick_q      <= 1'b0;
            blank_q     <= 1'b0;
            seg         <= SegBlank;
            an          <= AnOff;
            dp          <= 1'b1;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            tick_q  <= tick;
            if (tick) begin
                idx_q   <= idx_q + 2'd1;
                blank_q <= blank_en;
            end
            if (wrap) begin
                snap_bcd_q  <= bcd_in;
                snap_page_q <= page_e'(page_sel);
            end
            // Outputs follow the index one cycle after it moves.
            if (tick_q) begin
                seg <= seg_d;
                an  <= an_d;
                dp  <= dp_d;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan (SCAN_DIV=4).
// Blink checks are included when SEG_BLINK_EN is defined.
module tb_seven_seg_scan;
    import seg_pkg::*;

    localparam int unsigned ScanDiv     = 4;
    localparam int unsigned BlinkFrames = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bcd_in;
    logic        page_sel;
    logic        blank_en;
`ifdef SEG_BLINK_EN
    logic        blink;
`endif
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .SCAN_DIV     (ScanDiv),
        .BLINK_FRAMES (BlinkFrames)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .page_sel (page_sel),
        .blank_en (blank_en),
`ifdef SEG_BLINK_EN
        .blink    (blink),
`endif
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    task automatic check_out(input string tag, input logic [3:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_dp);
        n_checks++;
        assert ({an, seg, dp} === {exp_an, exp_seg, exp_dp}) else begin
            n_fail++;
            $error("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   tag, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
    endtask

    task automatic check_slot(input string tag, input int idx, input logic [6:0] exp_seg);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << idx);
        check_out(tag, exp_an, exp_seg, (idx != 2));
    endtask

    // Advance one slot and land on the negedge after the output update.
    task automatic adv();
        repeat (ScanDiv) @(posedge clk);
        @(negedge clk);
    endtask

    // From the idx3 sample point, check a whole frame (idx0..idx3).
    task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input bit blank3);
        adv(); check_slot({tag, "_idx0"}, 0, s0);
        adv(); check_slot({tag, "_idx1"}, 1, s1);
        adv(); check_slot({tag, "_idx2"}, 2, s2);
        adv();
        if (blank3) check_out({tag, "_idx3"}, 4'b1111, SegBlank, 1'b1);
        else        check_slot({tag, "_idx3"}, 3, s3);
    endtask

`ifdef SEG_BLINK_EN
    task automatic frame_an(input string tag, input bit off);
        logic [3:0] exp_an;
        for (int i = 0; i < 4; i++) begin
            adv();
            exp_an = off ? 4'b1111 : ~(4'b0001 << i);
            n_checks++;
            assert (an === exp_an) else begin
                n_fail++;
                $error("FAIL %s slot %0d: got an=%b, expected an=%b", tag, i, an, exp_an);
            end
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        bcd_in   = 24'h123456;
        page_sel = 1'b0;
        blank_en = 1'b0;
`ifdef SEG_BLINK_EN
        blink    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("reset", 4'b1111, SegBlank, 1'b1);
        rst = 1'b0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_out("pre_first_update", 4'b1111, SegBlank, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_slot("p0_idx0", 0, Seg4);
        adv(); check_slot("p0_idx1", 1, Seg3);
        adv(); check_slot("p0_idx2", 2, Seg2);
        adv(); check_slot("p0_idx3", 3, Seg1);

        bcd_in = 24'h12345F; page_sel = 1'b1;
        frame("p1", SegDash, Seg5, Seg4, Seg3, 1'b0);

        bcd_in = 24'h000000; page_sel = 1'b0; blank_en = 1'b1;
        frame("blank_on", Seg0, Seg0, Seg0, Seg0, 1'b1);

        bcd_in = 24'h012345;
        frame("blank_lead", Seg3, Seg2, Seg1, Seg0, 1'b1);

        bcd_in = 24'h000000; blank_en = 1'b0;
        frame("blank_off", Seg0, Seg0, Seg0, Seg0, 1'b0);

        // Input change mid-frame must wait for the next wrap.
        bcd_in = 24'h000001; page_sel = 1'b1;
        adv(); check_slot("tear_idx0", 0, Seg1);
        adv(); check_slot("tear_idx1", 1, Seg0);
        bcd_in = 24'h000002;
        adv(); check_slot("tear_idx2", 2, Seg0);
        adv(); check_slot("tear_idx3", 3, Seg0);
        adv(); check_slot("tear_new_idx0", 0, Seg2);
        adv(); check_slot("tear_new_idx1", 1, Seg0);
        adv(); check_slot("tear_new_idx2", 2, Seg0);
        adv(); check_slot("tear_new_idx3", 3, Seg0);

        bcd_in = 24'h123400; page_sel = 1'b0;
        adv(); check_slot("tear2_idx0", 0, Seg4);
        adv(); check_slot("tear2_idx1", 1, Seg3);
        bcd_in = 24'h987600; page_sel = 1'b1;
        adv(); check_slot("tear2_idx2", 2, Seg2);
        adv(); check_slot("tear2_idx3", 3, Seg1);
        frame("tear2_new", Seg0, Seg0, Seg6, Seg7, 1'b0);

        // Mid-frame reset.
        bcd_in = 24'h123456; page_sel = 1'b0;
        adv(); check_slot("pre_rst_idx0", 0, Seg4);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out("mid_rst", 4'b1111, SegBlank, 1'b1);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_out("post_rst_pre", 4'b1111, SegBlank, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_slot("post_rst_idx0", 0, Seg4);
        adv(); check_slot("post_rst_idx1", 1, Seg3);
        adv(); check_slot("post_rst_idx2", 2, Seg2);
        adv(); check_slot("post_rst_idx3", 3, Seg1);

`ifdef SEG_BLINK_EN
        rst   = 1'b1;
        blink = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        frame_an("blink_f0", 1'b0);
        frame_an("blink_f1", 1'b0);
        frame_an("blink_f2", 1'b1);
        frame_an("blink_f3", 1'b1);
        frame_an("blink_f4", 1'b0);
        blink = 1'b0;
        frame_an("noblink_a", 1'b0);
        frame_an("noblink_b", 1'b0);
        frame_an("noblink_c", 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot (1 kHz per digit at 50 MHz); legal range is at least 2.
REQ-002 SHALL have parameter BLINK_FRAMES, default 128, meaning scan frames per blink half-period (used only with SEG_BLINK_EN).
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high, named rst.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state changes on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port bcd_in, input, 24 bits: {min_l, min_r, sec_l, sec_r, cen_l, cen_r}, 4-bit BCD each, from the stopwatch display bus.
REQ-007 SHALL have port page_sel, input, 1 bit: 0 shows MM.SS, 1 shows SS.cc.
REQ-008 SHALL have port blank_en, input, 1 bit: enables leading-zero blanking.
REQ-009 SHALL have port blink, input, 1 bit, present only with SEG_BLINK_EN.
REQ-010 SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-012 SHALL have port an, output, 4 bits: digit anodes, active-low; an[0] is the rightmost digit.

Function
REQ-013 SHALL run a prescaler from 0 to SCAN_DIV-1 and wrap; tick is high for one cycle when the count equals SCAN_DIV-1.
REQ-014 SHALL advance a 2-bit digit index on each tick in the order 0,1,2,3,0.
REQ-015 SHALL load a 24-bit snapshot of bcd_in and a 1-bit snapshot of page_sel on the tick where the index wraps 3->0; mid-frame input changes SHALL NOT be displayed until the next frame.
REQ-016 SHALL map digits as follows: page 0 is idx3=min_l, idx2=min_r, idx1=sec_l, idx0=sec_r; page 1 is idx3=sec_l, idx2=sec_r, idx1=cen_l, idx0=cen_r.
REQ-017 SHALL register seg, an and dp so they update on the cycle after the tick, giving a latency of 1 clk from the index change.
REQ-018 SHALL drive exactly one an bit low per slot, at position idx.
REQ-019 SHALL decode 0 to 9 to the standard active-low patterns (0=1000000, 1=1111001, 8=0000000); nibble values 10 to 15 SHALL display a dash (0111111).
REQ-020 SHALL light dp (drive it 0) only when idx=2; otherwise dp SHALL be 1.
REQ-021 SHALL, when blank_en=1 and the idx3 digit is 0, drive seg=1111111 and an=1111 for that slot; lower digits SHALL never be blanked.
REQ-022 SHALL sample blank_en live at the tick.
REQ-023 SHALL wrap the prescaler and index freely with no saturation.

Reset
REQ-024 SHALL, when rst is high at posedge, set the prescaler to 0, idx to 3, snapshot to 0, seg to 1111111, an to 1111 and dp to 1.
REQ-025 SHALL have its first tick after reset wrap idx 3->0 and load the snapshot.
REQ-026 SHALL abort the frame immediately on a mid-frame rst; no partial-frame output SHALL persist.

Configuration
REQ-027 SHALL, with SEG_BLINK_EN defined, add the blink port and a frame counter over BLINK_FRAMES; while blink=1, all anodes SHALL be 1111 during odd half-periods; when blink=0 the counter SHALL hold at 0.
REQ-028 SHALL, without SEG_BLINK_EN, have no blink port, no frame counter, and display continuously.

Structure
REQ-029 SHALL place the segment pattern constants (digits 0 to 9, dash, blank) and the page encoding in shared package seg_pkg.
REQ-030 SHALL isolate BCD-to-segment decode in combinational sub-module seg_decoder (4-bit in, 7-bit active-low out).

Verification
REQ-031 SHALL cover reset: with SCAN_DIV=4 and rst held 3 cycles, an=1111, seg=1111111 and dp=1; the first tick lands at cycle 4 after release and an=1110 one cycle later.
REQ-032 SHALL cover page 0: bcd_in=0x123456, page_sel=0; slots idx0..3 show 4,3,2,1 and dp is low only on an=1011.
REQ-033 SHALL cover page 1 with invalid BCD: bcd_in=0x12345F, page_sel=1; slots show dash,5,4,3.
REQ-034 SHALL cover blanking: bcd_in=0x000000, blank_en=1, page 0; the idx3 slot has an=1111 and idx0..2 show 0; with blank_en=0 all four show 0.
REQ-035 SHALL cover anti-tearing: change bcd_in 0x000001->0x000002 while idx=1; the remaining frame shows old digits and the new value appears only after the 3->0 wrap.
REQ-036 SHALL cover blink: with SEG_BLINK_EN, BLINK_FRAMES=2 and blink=1, an=1111 for frames 2 to 3, normal for frames 0 to 1; blink=0 gives continuous display.
